sysid_check_ctrl: RTL and testbench

//  Avalon-MM read master that sequences the system-ID slave after reset or on request.

---
 rtl/sysid_check_ctrl.sv | 129 ++++++++++++
 tb/tb_sysid_check_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_check_ctrl.sv
// Avalon-MM read master that fetches the system-ID (and optionally timestamp) words and checks them.
// Define SYSID_TS_CHECK_EN to include the timestamp read and compare.
module sysid_check_ctrl #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1319521005,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          MAX_RETRY      = 2,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        av_address,
  output logic        av_read,
  input  logic        av_waitrequest,
  input  logic [31:0] av_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, CHECK, DONE} state_t;

  localparam logic [15:0] TO_LIMIT    = 16'(TIMEOUT_CYCLES);
  localparam logic [1:0]  LAT_LAST    = 2'(READ_LATENCY - 1);
  localparam logic [2:0]  RETRY_LIMIT = 3'(MAX_RETRY);
  localparam bit          NO_LAT      = (READ_LATENCY == 0);

  state_t      state, state_nxt, after_id;
  logic [15:0] to_cnt;
  logic [1:0]  lat_cnt;
  logic [2:0]  retry_cnt;
  logic        auto_pend;
  logic        rd_phase, expired, accept, lat_done, retry_ok, cap_id, enter_id;

`ifdef SYSID_TS_CHECK_EN
  assign after_id = RD_TS;
`else
  assign after_id = CHECK;
`endif

  // A stall that has used up its budget gets one dead cycle with av_read low.
  assign rd_phase = (state == RD_ID) || (state == RD_TS);
  assign expired  = rd_phase && (to_cnt == TO_LIMIT);
  assign accept   = av_read && !av_waitrequest;
  assign lat_done = ((state == LAT_ID) || (state == LAT_TS)) && (lat_cnt == LAT_LAST);
  assign retry_ok = retry_cnt < RETRY_LIMIT;
  assign cap_id   = ((state == RD_ID) && accept && NO_LAT) || ((state == LAT_ID) && lat_done);
  assign enter_id = (state_nxt == RD_ID) && ((state == IDLE) || expired);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    av_read    = rd_phase && !expired;
    av_address = (state == RD_TS);
    busy       = (state != IDLE) && (state != DONE);
    done       = (state == DONE);
    case (state)
      IDLE:    if (auto_pend || start) state_nxt = RD_ID;
      RD_ID: begin
        if (expired)     state_nxt = retry_ok ? RD_ID : DONE;
        else if (accept) state_nxt = NO_LAT ? after_id : LAT_ID;
      end
      LAT_ID:  if (lat_done) state_nxt = after_id;
      RD_TS: begin
        if (expired)     state_nxt = retry_ok ? RD_ID : DONE;
        else if (accept) state_nxt = NO_LAT ? CHECK : LAT_TS;
      end
      LAT_TS:  if (lat_done) state_nxt = CHECK;
      CHECK:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt      <= '0;
      lat_cnt     <= '0;
      retry_cnt   <= '0;
      auto_pend   <= AUTO_START;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      if (state == IDLE) auto_pend <= 1'b0;
      to_cnt  <= (av_read && av_waitrequest) ? to_cnt + 16'd1 : '0;
      lat_cnt <= (((state == LAT_ID) || (state == LAT_TS)) && !lat_done) ? lat_cnt + 2'd1 : '0;
      if (state == DONE)            retry_cnt <= '0;
      else if (expired && retry_ok) retry_cnt <= retry_cnt + 3'd1;
      if (enter_id) begin
        pass        <= 1'b0;
        id_mismatch <= 1'b0;
        ts_mismatch <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (expired && !retry_ok) timeout_err <= 1'b1;
      if (cap_id) id_value <= av_readdata;
`ifdef SYSID_TS_CHECK_EN
      if (((state == RD_TS) && accept && NO_LAT) || ((state == LAT_TS) && lat_done))
        ts_value <= av_readdata;
      if (state == CHECK) begin
        id_mismatch <= (id_value != EXPECTED_ID);
        ts_mismatch <= (ts_value != EXPECTED_TS);
        pass        <= (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS) && !timeout_err;
      end
`else
      if (state == CHECK) begin
        id_mismatch <= (id_value != EXPECTED_ID);
        pass        <= (id_value == EXPECTED_ID) && !timeout_err;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Bench for sysid_check_ctrl: two instances (read latency 0 and 2) against a bus-level slave
// and a transaction-level model of sequence length, retries and result flags.
module tb_sysid_check_ctrl;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1319521005;
  localparam int TO   = 8;
  localparam int MAXR = 2;
  localparam int RL0  = 0;
  localparam int RL1  = 2;
`ifdef SYSID_TS_CHECK_EN
  localparam bit TS_ON = 1'b1;
`else
  localparam bit TS_ON = 1'b0;
`endif

  logic        clock, reset_n, start;
  logic        av_address [2];
  logic        av_read [2];
  logic        av_waitrequest [2];
  logic [31:0] av_readdata [2];
  logic        busy [2];
  logic        done [2];
  logic        pass [2];
  logic        id_mismatch [2];
  logic        ts_mismatch [2];
  logic        timeout_err [2];
  logic [31:0] id_value [2];
  logic [31:0] ts_value [2];

  sysid_check_ctrl #(.EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(RL0),
                     .TIMEOUT_CYCLES(TO), .MAX_RETRY(MAXR), .AUTO_START(1'b1)) u0 (
    .clock(clock), .reset_n(reset_n), .start(start),
    .av_address(av_address[0]), .av_read(av_read[0]), .av_waitrequest(av_waitrequest[0]),
    .av_readdata(av_readdata[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .id_mismatch(id_mismatch[0]), .ts_mismatch(ts_mismatch[0]), .timeout_err(timeout_err[0]),
    .id_value(id_value[0]), .ts_value(ts_value[0]));

  sysid_check_ctrl #(.EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(RL1),
                     .TIMEOUT_CYCLES(TO), .MAX_RETRY(MAXR), .AUTO_START(1'b1)) u1 (
    .clock(clock), .reset_n(reset_n), .start(start),
    .av_address(av_address[1]), .av_read(av_read[1]), .av_waitrequest(av_waitrequest[1]),
    .av_readdata(av_readdata[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .id_mismatch(id_mismatch[1]), .ts_mismatch(ts_mismatch[1]), .timeout_err(timeout_err[1]),
    .id_value(id_value[1]), .ts_value(ts_value[1]));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;

  logic [31:0] id_word [2];
  logic [31:0] ts_word [2];
  int          plan [2][16];
  int          plan_idx [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rl_of(input int i);
    return (i == 0) ? RL0 : RL1;
  endfunction

  function automatic int plan_at(input int i, input int k);
    return (k < 16) ? plan[i][k] : 0;
  endfunction

  task automatic fill_plan(input int i, input int v);
    for (int k = 0; k < 16; k++) plan[i][k] = v;
  endtask

  task automatic rand_plan(input int i);
    int r;
    for (int k = 0; k < 16; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 12)      plan[i][k] = TO + int'($urandom_range(0, 3));
      else if (r < 20) plan[i][k] = TO - 1;
      else             plan[i][k] = int'($urandom_range(0, 3));
    end
  endtask

  // Each read attempt stalls s cycles then is accepted; s >= TO burns TO stalls plus a dead cycle.
  function automatic void model(input int i, output int dcyc, output int rcyc, output bit tmo);
    int idx, s;
    bit ok;
    idx = 0; dcyc = 0; rcyc = 0; tmo = 1'b0;
    for (int att = 0; att <= MAXR; att++) begin
      ok = 1'b1;
      for (int r = 0; r < (TS_ON ? 2 : 1); r++) begin
        s = plan_at(i, idx);
        idx++;
        if (s >= TO) begin
          dcyc += TO + 1; rcyc += TO; ok = 1'b0;
          break;
        end
        dcyc += s + 1 + rl_of(i);
        rcyc += s + 1;
      end
      if (ok) begin
        dcyc += 2;
        return;
      end
    end
    dcyc += 1;
    tmo = 1'b1;
  endfunction

  task automatic check_reset(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s.u%0d.av_read", tag, i), av_read[i], 0);
      check($sformatf("%s.u%0d.av_address", tag, i), av_address[i], 0);
      check($sformatf("%s.u%0d.busy", tag, i), busy[i], 0);
      check($sformatf("%s.u%0d.done", tag, i), done[i], 0);
      check($sformatf("%s.u%0d.flags", tag, i),
            {pass[i], id_mismatch[i], ts_mismatch[i], timeout_err[i]}, 0);
      check($sformatf("%s.u%0d.id_value", tag, i), id_value[i], 0);
      check($sformatf("%s.u%0d.ts_value", tag, i), ts_value[i], 0);
    end
  endtask

  task automatic run_seq(input bit pulse, input int tail, input bit start_at_done, input string name);
    int          iter, last, slot, dcyc, rcyc;
    bit          fin, tmo, st;
    bit          started [2];
    int          first [2], done_iter [2], done_cnt [2], rd_cnt [2], extra [2], rem [2];
    logic        busy_first [2], busy_done [2], prev_rd [2], prev_addr [2], wq;
    logic [31:0] pd [2][4];
    bit          pv [2][4];
    bit          idm, tsm;
    for (int i = 0; i < 2; i++) begin
      started[i] = 0; first[i] = 0; done_iter[i] = 0; done_cnt[i] = 0; rd_cnt[i] = 0;
      extra[i] = 0; rem[i] = 0; busy_first[i] = 0; busy_done[i] = 1; prev_rd[i] = 0;
      prev_addr[i] = 0; plan_idx[i] = 0;
      for (int k = 0; k < 4; k++) begin pd[i][k] = '0; pv[i][k] = 0; end
    end
    iter = 0; fin = 0;
    while (!fin && iter < 300) begin
      @(negedge clock);
      st = 0;
      for (int i = 0; i < 2; i++) begin
        if (!started[i] && av_read[i]) begin
          started[i] = 1; first[i] = iter; busy_first[i] = busy[i];
        end
        if (done[i]) begin
          done_cnt[i]++;
          if (done_cnt[i] == 1) begin
            done_iter[i] = iter; busy_done[i] = busy[i];
            if (i == 0 && start_at_done) st = 1;
          end
        end
        if (av_read[i]) begin
          if (done_cnt[i] > 0) extra[i]++;
          else                 rd_cnt[i]++;
          if (!prev_rd[i] || prev_addr[i] != av_address[i]) begin
            rem[i] = plan_at(i, plan_idx[i]);
            plan_idx[i]++;
          end
          wq = (rem[i] > 0);
          if (wq) rem[i]--;
          else begin
            slot = (iter + rl_of(i)) % 4;
            pd[i][slot] = av_address[i] ? ts_word[i] : id_word[i];
            pv[i][slot] = 1;
          end
        end else begin
          wq = 1'($urandom_range(0, 1));
        end
        av_waitrequest[i] = wq;
        slot = iter % 4;
        if (pv[i][slot]) begin
          av_readdata[i] = pd[i][slot];
          pv[i][slot] = 0;
        end else begin
          av_readdata[i] = $urandom;
        end
        prev_rd[i] = av_read[i];
        prev_addr[i] = av_address[i];
      end
      if (pulse && (iter == 0 || iter == 2)) st = 1;
      start = st;
      last = (done_iter[0] > done_iter[1]) ? done_iter[0] : done_iter[1];
      if (done_cnt[0] > 0 && done_cnt[1] > 0 && iter >= last + tail) fin = 1;
      iter++;
    end
    start = 1'b0;
    check($sformatf("%s.finished", name), fin, 1);
    for (int i = 0; i < 2; i++) begin
      model(i, dcyc, rcyc, tmo);
      check($sformatf("%s.u%0d.first_read", name, i), started[i] ? first[i] : -1, pulse ? 1 : 0);
      check($sformatf("%s.u%0d.done_cycle", name, i), done_iter[i] - first[i] + 1, dcyc);
      check($sformatf("%s.u%0d.done_pulses", name, i), done_cnt[i], 1);
      check($sformatf("%s.u%0d.read_cycles", name, i), rd_cnt[i], rcyc);
      check($sformatf("%s.u%0d.reads_after_done", name, i), extra[i], 0);
      check($sformatf("%s.u%0d.busy_start", name, i), busy_first[i], 1);
      check($sformatf("%s.u%0d.busy_at_done", name, i), busy_done[i], 0);
      check($sformatf("%s.u%0d.timeout_err", name, i), timeout_err[i], tmo);
      if (tmo) begin
        check($sformatf("%s.u%0d.tmo_flags", name, i), {pass[i], id_mismatch[i], ts_mismatch[i]}, 0);
      end else begin
        idm = (id_word[i] != EXP_ID);
        tsm = TS_ON && (ts_word[i] != EXP_TS);
        check($sformatf("%s.u%0d.id_mismatch", name, i), id_mismatch[i], idm);
        check($sformatf("%s.u%0d.ts_mismatch", name, i), ts_mismatch[i], tsm);
        check($sformatf("%s.u%0d.pass", name, i), pass[i], !idm && !tsm);
        check($sformatf("%s.u%0d.id_value", name, i), id_value[i], id_word[i]);
        check($sformatf("%s.u%0d.ts_value", name, i), ts_value[i], TS_ON ? ts_word[i] : 32'd0);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      av_waitrequest[i] = 1'b1; av_readdata[i] = '0;
      id_word[i] = EXP_ID; ts_word[i] = EXP_TS; plan_idx[i] = 0;
      fill_plan(i, 0);
    end
    repeat (3) @(negedge clock);
    check_reset("reset");

    reset_n = 1'b1;
    run_seq(0, 2, 0, "auto_match");

    for (int i = 0; i < 2; i++) id_word[i] = 32'h12345678;
    run_seq(1, 2, 0, "id_wrong");

    for (int i = 0; i < 2; i++) begin id_word[i] = EXP_ID; fill_plan(i, 20); end
    run_seq(1, 2, 0, "stuck_wait");

    for (int i = 0; i < 2; i++) begin fill_plan(i, 0); plan[i][0] = 3; end
    run_seq(1, 2, 0, "stall3");

    for (int i = 0; i < 2; i++) begin fill_plan(i, TO - 1); end
    run_seq(1, 2, 0, "stall_limit");

    for (int i = 0; i < 2; i++) begin fill_plan(i, 0); plan[i][0] = TO; end
    run_seq(1, 2, 0, "one_retry");

    for (int i = 0; i < 2; i++) begin fill_plan(i, 0); ts_word[i] = EXP_TS ^ 32'h1; end
    run_seq(1, 3, 1, "start_at_done");

    for (int i = 0; i < 2; i++) ts_word[i] = EXP_TS;
    run_seq(1, 0, 0, "no_tail");
    run_seq(1, 2, 0, "first_idle");

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 2; i++) begin
        id_word[i] = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
        ts_word[i] = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
        rand_plan(i);
      end
      run_seq(1, 1, 0, $sformatf("rand%0d", n));
    end

    for (int i = 0; i < 2; i++) av_waitrequest[i] = 1'b1;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (3) @(negedge clock);
    check("midread.av_read_before", av_read[0], 1);
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("midread.u%0d.av_read_async", i), av_read[i], 0);
      check($sformatf("midread.u%0d.busy_async", i), busy[i], 0);
    end
    repeat (2) @(negedge clock);
    check_reset("midread");
    for (int i = 0; i < 2; i++) begin fill_plan(i, 0); id_word[i] = EXP_ID; ts_word[i] = EXP_TS; end
    reset_n = 1'b1;
    run_seq(0, 2, 0, "relaunch");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
